// File: rtl/rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4 : four-way round-robin arbiter for the shared 4:1 mux path
//
// Four requesters A..D (req[0]..req[3], mux inputs ina..ind) compete for one
// shared path. The arbiter grants one requester and drives sel to its index.
// The grant is held until the owner signals done, drops its request (abort),
// or holds the path for HOLD_MAX cycles (forced release with a timeout pulse).
// Every release is followed by at least one idle cycle before the next grant.
// All outputs are registered.
//
// Parameters
//   HOLD_MAX  max cycles a grant may be held before forced release
//             (1 .. 2**CNT_W-1)
//   CNT_W     width of the hold counter
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   req      in   4  request per source; bit0 = A (ina) .. bit3 = D (ind)
//   done     in   1  granted source finished its transfer this cycle
//   lock     in   1  keep priority on current owner (RR_ARB4_LOCK_EN only)
//   sel      out  2  binary index of current/last owner, to mux select
//   grant    out  4  one-hot grant, all-zero when idle
//   busy     out  1  high while in GRANT state
//   timeout  out  1  one-cycle pulse on forced release
//
// Configuration
//   RR_ARB4_LOCK_EN  when defined, adds the lock input. While locked the hold
//                    counter is frozen (no timeout) and a release keeps the
//                    pointer on the owner so it has first priority next time.
//                    When undefined the arbiter behaves as if lock=0.
// -----------------------------------------------------------------------------
module rr_arb4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
`ifdef RR_ARB4_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_nxt;
    logic [3:0]         r_grant;
    logic [3:0]         w_grant_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_lock;
    logic [7:0]         w_req2;
    logic [3:0]         w_rot;
    logic [1:0]         w_off;
    logic [1:0]         w_win;
    logic               w_owner_req;
    logic               w_rel_norm;
    logic               w_at_limit;

`ifdef RR_ARB4_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Rotate the request vector so that bit 0 corresponds to the pointer
    // position; the lowest set bit of the rotated vector is then the winner's
    // offset from the pointer, and the 2-bit add wraps D+1 back to A.
    assign w_req2 = {req, req};
    assign w_rot  = w_req2[r_ptr +: 4];

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign w_win = r_ptr + w_off;

    // In GRANT the select register always holds the owner's index.
    assign w_owner_req = req[r_sel];
    // done takes precedence over abort and timeout; abort over timeout.
    assign w_rel_norm  = done | ~w_owner_req;
    assign w_at_limit  = (r_cnt == CNT_W'(HOLD_MAX - 1));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // sel is left alone when nobody requests so the mux output
                // stays on the last owner.
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            S_GRANT: begin
                if (w_rel_norm || (!w_lock && w_at_limit)) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_busy_nxt    = 1'b0;
                    // A locked owner keeps first priority for the next round.
                    w_ptr_nxt     = w_lock ? r_sel : r_sel + 2'd1;
                    w_timeout_nxt = ~w_rel_norm;
                end else if (!w_lock) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_sel     <= 2'd0;
            r_grant   <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign sel     = r_sel;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb4.sv
// -----------------------------------------------------------------------------
// tb_rr_arb4 : self-checking bench for rr_arb4 (default build, no lock port)
// A behavioural model tracks owner / held-cycle count / pointer as integers
// and is compared against the DUT on every falling edge; directed sequences
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rr_arb4;

    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_vec;
    int n_err;

    rr_arb4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_owner = -1 when idle, else index of granted source.
    // m_held  = number of cycles the current owner has been granted.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_sel;
    int m_to;

    always @(posedge clk or posedge rst) begin
        int o, h, p, s, t, cand;
        if (rst) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= 0;
            m_sel   <= 0;
            m_to    <= 0;
        end else begin
            o = m_owner; h = m_held; p = m_ptr; s = m_sel; t = 0;
            if (o < 0) begin
                for (int i = 0; i < 4; i++) begin
                    cand = (p + i) % 4;
                    if (o < 0 && req[cand]) o = cand;
                end
                if (o >= 0) begin
                    s = o;
                    h = 1;
                end
            end else begin
                if (done || !req[o]) begin
                    p = (o + 1) % 4;
                    o = -1;
                end else if (h == HOLD_MAX) begin
                    p = (o + 1) % 4;
                    o = -1;
                    t = 1;
                end else begin
                    h = h + 1;
                end
            end
            m_owner <= o;
            m_held  <= h;
            m_ptr   <= p;
            m_sel   <= s;
            m_to    <= t;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("grant", int'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
            check("sel", int'(sel), m_sel);
            check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
            check("timeout", int'(timeout), m_to);
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cnt;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout), 0);
        rst = 1'b0;

        // T1: async reset mid-grant with owner C
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        check("t1_grant_c", int'(grant), 4);
        check("t1_sel_c", int'(sel), 2);
        #2 rst = 1'b1;
        #1;
        check("t1_async_grant", int'(grant), 0);
        check("t1_async_sel", int'(sel), 0);
        check("t1_async_busy", int'(busy), 0);
        check("t1_async_timeout", int'(timeout), 0);
        req = 4'b0000;
        #1 rst = 1'b0;

        // T2: round robin with all requesting, done during each grant cycle
        @(negedge clk);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_grant", int'(grant), 1 << (k % 4));
            check("t2_sel", int'(sel), k % 4);
            done = 1'b1;
            @(negedge clk);
            check("t2_idle_grant", int'(grant), 0);
            check("t2_idle_sel", int'(sel), k % 4);
            done = 1'b0;
        end
        req = 4'b0000;

        // T3: abort by B, pointer moves to C
        @(negedge clk);
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_grant_b", int'(grant), 2);
        end
        req = 4'b0000;
        @(negedge clk);
        check("t3_abort_grant", int'(grant), 0);
        check("t3_abort_timeout", int'(timeout), 0);
        req = 4'b1111;
        @(negedge clk);
        check("t3_next_is_c", int'(grant), 4);
        done = 1'b1;
        req  = 4'b0000;
        @(negedge clk);
        done = 1'b0;

        // T4: timeout of D after exactly HOLD_MAX grant cycles
        req = 4'b1000;
        cnt = 0;
        for (int k = 0; k < HOLD_MAX + 5; k++) begin
            @(negedge clk);
            if (grant == 4'b1000) cnt++;
            else break;
        end
        check("t4_hold_cycles", cnt, HOLD_MAX);
        check("t4_rel_grant", int'(grant), 0);
        check("t4_timeout_pulse", int'(timeout), 1);
        @(negedge clk);
        check("t4_regrant_d", int'(grant), 8);
        check("t4_timeout_clear", int'(timeout), 0);
        req = 4'b0000;
        @(negedge clk);
        check("t4_abort_grant", int'(grant), 0);

        // T5: done coincides with the hold limit
        req = 4'b0001;
        @(negedge clk);
        check("t5_grant_a", int'(grant), 1);
        repeat (HOLD_MAX - 1) @(negedge clk);
        check("t5_still_a", int'(grant), 1);
        done = 1'b1;
        @(negedge clk);
        check("t5_rel_grant", int'(grant), 0);
        check("t5_no_timeout", int'(timeout), 0);
        done = 1'b0;
        req  = 4'b0000;
        @(negedge clk);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 11) == 0);
            if (k == 1500) begin
                #2 rst = 1'b1;
                #1 check("rnd_async_grant", int'(grant), 0);
                #1 rst = 1'b0;
            end
        end
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
